meas_tx_buffer: RTL and testbench
=================================

Name: meas_tx_buffer

Overview:
- Byte-level elastic buffer that sits directly upstream of the SPI slave transmitter.
- Accepts 16-bit compressed-sensing measurement samples from the measurement datapath over a valid/ready handshake and splits each into two bytes, MSB byte first.
- Queues the bytes in a FIFO and presents the head byte on the transmitter's parallel data input.
- Advances one byte per transmitter byte-sent pulse; enables the transmitter once data has arrived.

Parameters:
SAMPLE_W, 16, sample width in bits; fixed at 16 (two bytes per sample)
DEPTH, 16, FIFO depth in bytes; power of two, minimum 4
PAD_BYTE, 8'h00, byte presented when the FIFO is empty

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_in  in  16  measurement sample
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  block can accept a sample this cycle
data  out  8  byte presented to the SPI transmitter
byte_sent  in  1  one-cycle pulse from the transmitter: current data byte has been consumed
tx_enable  out  1  enables the SPI transmitter (drives its signalReceived input)
fill  out  log2(DEPTH)+1  bytes currently queued
underflow_cnt  out  8  saturating count of byte_sent pulses received while the FIFO was empty

Behaviour:
- Reset: all state clears; all outputs return to these values, including reset mid-operation.
  - FIFO empty, fill=0, data=PAD_BYTE.
  - sample_ready=0 in the reset cycle, then 1.
  - tx_enable=0, underflow_cnt=0, split FSM in IDLE.
  - Any partially split sample is discarded.
- Split FSM (states IDLE, LO_PENDING):
  - IDLE: a sample is accepted when sample_valid && sample_ready. The same cycle, sample_in[15:8] is written to the FIFO and sample_in[7:0] is latched. Next state is LO_PENDING.
  - LO_PENDING: the latched low byte is written to the FIFO. Next state is IDLE.
  - sample_ready=0 while in LO_PENDING, so the maximum accept rate is one sample per 2 cycles.
- sample_ready (registered) = state==IDLE && free slots >= 2, where free slots = DEPTH - fill, evaluated after the current cycle's push and pop.
  - Guarantees the low byte can never be dropped.
  - A whole sample is never split across a full condition.
- FIFO: circular buffer with read/write pointers one bit wider than the address; full/empty come from pointer comparison.
  - Pointer wrap at DEPTH is seamless.
  - At most one push and one pop per cycle. Simultaneous push and pop leave fill unchanged.
  - Pop on byte_sent when not empty.
  - Pop on an empty FIFO has no pointer effect; underflow_cnt increments, saturating at 8'hFF.
- data output is registered, showing the head entry one cycle after any pointer change.
  - Updates within 1 clk of a byte_sent pulse; the transmitter reloads 2 clk after its pulse, so timing is met.
  - PAD_BYTE whenever the FIFO is empty.
  - A write into an empty FIFO appears on data the following cycle.
- tx_enable:
  - Sets on the first FIFO write after reset.
  - Stays 1 until rst, so the transmitter keeps its SCK/SSEL tracking alive across empty periods (it then sends PAD_BYTE).
- byte_sent is treated as a single-cycle pulse. A pulse that stays high for N cycles pops N entries; no edge detection is done here.
- Push with full cannot occur by construction. An assertion in the bench checks this.
- fill is registered and exact: it increments on push only, decrements on pop only.

Decomposition:
- Shared package holds:
  - the byte type (8 bits)
  - SAMPLE_W
  - the PAD_BYTE default
  - split FSM state encoding (IDLE=1'b0, LO_PENDING=1'b1)
- One sub-module: byte_fifo (parameter DEPTH; push/pop/din/dout/empty/full/fill), a generic synchronous FIFO reusable by the receive path.
- meas_tx_buffer contains the split FSM, handshake logic, underflow counter and tx_enable flag.

Test Plan:
1. Reset, then one sample 16'hA55A with valid for 1 cycle:
   - sample_ready drops the next cycle.
   - fill goes 1 then 2.
   - data=8'hA5 one cycle after the first write.
   - tx_enable=1.
   - After a byte_sent pulse, data=8'h5A within 1 clk.
   - After a second pulse, data=8'h00 and fill=0.
2. Back-to-back valid with samples 16'h0102 .. 16'h0809 and no byte_sent, DEPTH=16:
   - Accepts every other cycle.
   - sample_ready goes 0 when fill=16.
   - sample_valid is held and the 9th sample is not accepted.
   - Drain with 16 pulses yields bytes 01,02,...,08,09 in order.
3. Simultaneous push and pop at fill=8 for 20 cycles:
   - fill stays 8.
   - Byte order is preserved across pointer wrap.
4. With the FIFO empty, 3 byte_sent pulses:
   - data stays 8'h00.
   - underflow_cnt=3; pointers are unchanged.
   - 300 further pulses saturate underflow_cnt at 8'hFF.
5. Assert rst while in LO_PENDING with fill=6:
   - The next cycle fill=0, data=8'h00, tx_enable=0, underflow_cnt=0.
   - The latched low byte never appears on data.
6. Fill to 15 (odd, achieved via a single pop):
   - sample_ready=0, since free=1.
   - After one more pop, sample_ready=1 and one sample is accepted, bringing fill to 16.

Source files
------------

// File: rtl/meas_tx_buffer_pkg.sv
// Shared types and constants for the measurement transmit buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package meas_tx_buffer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int BYTE_W   = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t PAD_BYTE_DEFAULT = 8'h00;

    // Split FSM: high byte goes out on the accept cycle, low byte one cycle later.
    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_LO_PENDING = 1'b1
    } split_state_t;

endpackage

// File: rtl/meas_tx_buffer_byte_fifo.sv
// Generic synchronous byte FIFO with a registered head output.
// Latency: a write into an empty FIFO shows on o_dout the next cycle; o_dout follows any pop within 1 cycle.
// Backpressure: pushes while full and pops while empty are ignored; the caller watches o_full/o_empty.
//
// Ports: clk, rst (sync, active-high), i_push/i_din write side, i_pop read side,
//        o_dout head byte (PAD when empty), o_empty, o_full, o_fill (bytes queued).
module byte_fifo
    import meas_tx_buffer_pkg::*;
#(
    parameter int    DEPTH = 16,
    parameter byte_t PAD   = PAD_BYTE_DEFAULT,
    localparam int   AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  byte_t       i_din,
    input  logic        i_pop,
    output byte_t       o_dout,
    output logic        o_empty,
    output logic        o_full,
    output logic [AW:0] o_fill
);

    byte_t       r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_fill;
    byte_t       r_dout;

    logic        w_do_push;
    logic        w_do_pop;
    logic [AW:0] w_wr_ptr_nxt;
    logic [AW:0] w_rd_ptr_nxt;
    byte_t       w_head_nxt;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_push    = i_push && !o_full;
    assign w_do_pop     = i_pop && !o_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_do_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_do_pop);

    // Head after this cycle; bypass the write data when the new head is the slot being written.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
        if (w_rd_ptr_nxt == w_wr_ptr_nxt) begin
            w_head_nxt = PAD;
        end else if (w_do_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_dout   <= PAD;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_dout   <= w_head_nxt;
            if (w_do_push && !w_do_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_fill <= r_fill - 1'b1;
            end
        end
    end

    assign o_dout = r_dout;
    assign o_fill = r_fill;

endmodule

// File: rtl/meas_tx_buffer.sv
// Splits 16-bit measurement samples into bytes (MSB first) and queues them for the SPI slave transmitter.
// Latency: high byte enters the FIFO on the accept cycle, low byte the cycle after; head shows on data 1 cycle later.
// Backpressure: sample_ready is registered and drops in LO_PENDING or when fewer than 2 byte slots remain.
//
// Ports: clk, rst (sync, active-high); sample_in/sample_valid/sample_ready sample handshake;
//        data head byte to transmitter; byte_sent pop pulse; tx_enable transmitter enable;
//        fill bytes queued; underflow_cnt saturating count of pops on an empty FIFO.
module meas_tx_buffer
    import meas_tx_buffer_pkg::*;
#(
    parameter int    DEPTH    = 16,
    parameter byte_t PAD_BYTE = PAD_BYTE_DEFAULT,
    localparam int   FW       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic [7:0]          data,
    input  logic                byte_sent,
    output logic                tx_enable,
    output logic [FW-1:0]       fill,
    output logic [7:0]          underflow_cnt
);

    // Two free slots needed at accept time so the low byte always has room.
    localparam logic [FW-1:0] READY_MAX_FILL = FW'(DEPTH - 2);

    split_state_t  r_state;
    split_state_t  w_state_nxt;
    byte_t         r_lo_byte;
    logic          r_sample_ready;
    logic          r_tx_enable;
    logic [7:0]    r_underflow_cnt;

    logic          w_accept;
    logic          w_push;
    byte_t         w_din;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_push_ok;
    logic [FW-1:0] w_fill;
    logic [FW-1:0] w_fill_nxt;

    assign w_accept = sample_valid && r_sample_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:       if (w_accept) w_state_nxt = ST_LO_PENDING;
            ST_LO_PENDING: w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO write request and data
    always_comb begin
        w_push = 1'b0;
        w_din  = sample_in[15:8];
        case (r_state)
            ST_IDLE: begin
                w_push = w_accept;
                w_din  = sample_in[15:8];
            end
            ST_LO_PENDING: begin
                w_push = 1'b1;
                w_din  = r_lo_byte;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    assign w_pop      = byte_sent && !w_empty;
    assign w_push_ok  = w_push && !w_full;
    assign w_fill_nxt = w_fill + FW'(w_push_ok) - FW'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo_byte       <= '0;
            r_sample_ready  <= 1'b0;
            r_tx_enable     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_lo_byte <= sample_in[7:0];
            end
            r_sample_ready <= (w_state_nxt == ST_IDLE) && (w_fill_nxt <= READY_MAX_FILL);
            if (w_push_ok) begin
                r_tx_enable <= 1'b1;
            end
            if (byte_sent && w_empty && (r_underflow_cnt != 8'hFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .PAD   (PAD_BYTE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (byte_sent),
        .o_dout  (data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_fill  (w_fill)
    );

    assign sample_ready  = r_sample_ready;
    assign tx_enable     = r_tx_enable;
    assign fill          = w_fill;
    assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_meas_tx_buffer.sv
// Self-checking bench for meas_tx_buffer: byte order via a scoreboard queue, handshake, fill, underflow and reset.
// Latency: outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
// Backpressure: sample acceptance is predicted from sample_ready before each edge.
module tb_meas_tx_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  data;
    logic        byte_sent;
    logic        tx_enable;
    logic [4:0]  fill;
    logic [7:0]  underflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    meas_tx_buffer #(.DEPTH(16), .PAD_BYTE(8'h00)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .data          (data),
        .byte_sent     (byte_sent),
        .tx_enable     (tx_enable),
        .fill          (fill),
        .underflow_cnt (underflow_cnt)
    );

    // A high-byte push or low-byte push into a full FIFO must never happen.
    always @(posedge clk) begin
        if (!rst && dut.w_push && dut.w_full) begin
            n_fail++;
            $display("FAIL push_while_full: push asserted with fill=%0d, required no push", fill);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        byte_sent = 1'b1;
        tick();
        byte_sent = 1'b0;
    endtask

    // Offers n samples starting at base and records their bytes; waits for the low byte to land.
    task automatic fill_samples(input int n, input logic [15:0] base);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        sample_valid = 1'b1;
        while (acc < n && cyc < 200) begin
            sample_in = base + 16'(acc);
            if (sample_ready) begin
                exp_q.push_back(sample_in[15:8]);
                exp_q.push_back(sample_in[7:0]);
                acc++;
            end
            tick();
            cyc++;
        end
        sample_valid = 1'b0;
        tick();
        n_checks++;
        if (acc != n) begin
            n_fail++;
            $display("FAIL fill_samples_timeout: accepted %0d, required %0d", acc, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; sample_in = '0; byte_sent = 1'b0;
        tick();
        tick();
        n_checks++;
        if (fill !== 5'd0 || data !== 8'h00 || sample_ready !== 1'b0 || tx_enable !== 1'b0 || underflow_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: fill=%0d data=%h rdy=%b txen=%b uf=%0d, required 0 00 0 0 0",
                     fill, data, sample_ready, tx_enable, underflow_cnt);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b, required 1", sample_ready);
        end
    endtask

    task automatic test_single();
        sample_in = 16'hA55A; sample_valid = 1'b1;
        n_checks++;
        if (sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_before: got %b, required 1", sample_ready);
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        tick();
        sample_valid = 1'b0;
        n_checks++;
        if (sample_ready !== 1'b0 || fill !== 5'd1 || data !== 8'hA5 || tx_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after_accept: rdy=%b fill=%0d data=%h txen=%b, required 0 1 a5 1",
                     sample_ready, fill, data, tx_enable);
        end
        tick();
        n_checks++;
        if (fill !== 5'd2 || sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_fill2: fill=%0d rdy=%b, required 2 1", fill, sample_ready);
        end
        for (int i = 0; i < 2; i++) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (data !== exp_b) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h, required %h", i, data, exp_b);
            end
            pulse();
        end
        n_checks++;
        if (data !== 8'h00 || fill !== 5'd0 || tx_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL single_drained: data=%h fill=%0d txen=%b, required 00 0 1", data, fill, tx_enable);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int prev_acc;
        int bad_rate;
        idx = 0; prev_acc = 0; bad_rate = 0;
        sample_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            sample_in = {8'(idx + 1), 8'(idx + 2)};
            if (sample_ready) begin
                if (prev_acc != 0) bad_rate++;
                exp_q.push_back(sample_in[15:8]);
                exp_q.push_back(sample_in[7:0]);
                idx++;
                prev_acc = 1;
            end else begin
                prev_acc = 0;
            end
            tick();
        end
        n_checks++;
        if (idx != 8 || bad_rate != 0) begin
            n_fail++;
            $display("FAIL b2b_accepts: accepted %0d (back-to-back %0d), required 8 (0)", idx, bad_rate);
        end
        n_checks++;
        if (fill !== 5'd16 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: fill=%0d rdy=%b, required 16 0", fill, sample_ready);
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (data !== exp_b) begin
                n_fail++;
                $display("FAIL b2b_drain%0d: got %h, required %h", i, data, exp_b);
            end
            pulse();
        end
        n_checks++;
        if (fill !== 5'd0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_empty: fill=%0d data=%h, required 0 00", fill, data);
        end
    endtask

    task automatic test_simultaneous();
        int bad_fill;
        int bad_data;
        bad_fill = 0; bad_data = 0;
        fill_samples(4, 16'h3000);
        n_checks++;
        if (fill !== 5'd8) begin
            n_fail++;
            $display("FAIL simul_prefill: fill=%0d, required 8", fill);
        end
        sample_valid = 1'b1;
        byte_sent = 1'b1;
        for (int c = 0; c < 20; c++) begin
            exp_b = exp_q.pop_front();
            if (data !== exp_b) begin
                bad_data++;
                $display("FAIL simul_byte%0d: got %h, required %h", c, data, exp_b);
            end
            if (sample_ready) begin
                sample_in = 16'($urandom);
                exp_q.push_back(sample_in[15:8]);
                exp_q.push_back(sample_in[7:0]);
            end
            tick();
            if (fill !== 5'd8) begin
                bad_fill++;
                $display("FAIL simul_fill%0d: fill=%0d, required 8", c, fill);
            end
        end
        sample_valid = 1'b0;
        byte_sent = 1'b0;
        n_checks++;
        if (bad_data != 0) n_fail++;
        n_checks++;
        if (bad_fill != 0) n_fail++;
        tick();
        n_checks++;
        if (fill !== 5'(exp_q.size())) begin
            n_fail++;
            $display("FAIL simul_fill_end: fill=%0d, required %0d", fill, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (data !== exp_b) begin
                n_fail++;
                $display("FAIL simul_drain: got %h, required %h", data, exp_b);
            end
            pulse();
        end
    endtask

    task automatic test_underflow();
        byte_sent = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        byte_sent = 1'b0;
        n_checks++;
        if (data !== 8'h00 || underflow_cnt !== 8'd3 || fill !== 5'd0) begin
            n_fail++;
            $display("FAIL uf_three: data=%h uf=%0d fill=%0d, required 00 3 0", data, underflow_cnt, fill);
        end
        // Pointers must be untouched: a fresh sample still comes out intact.
        fill_samples(1, 16'hC33C);
        for (int i = 0; i < 2; i++) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (data !== exp_b) begin
                n_fail++;
                $display("FAIL uf_after_byte%0d: got %h, required %h", i, data, exp_b);
            end
            pulse();
        end
        byte_sent = 1'b1;
        for (int i = 0; i < 252; i++) tick();
        byte_sent = 1'b0;
        n_checks++;
        if (underflow_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL uf_255: got %0d, required 255", underflow_cnt);
        end
        byte_sent = 1'b1;
        for (int i = 0; i < 48; i++) tick();
        byte_sent = 1'b0;
        n_checks++;
        if (underflow_cnt !== 8'hFF || data !== 8'h00) begin
            n_fail++;
            $display("FAIL uf_saturate: uf=%0d data=%h, required 255 00", underflow_cnt, data);
        end
    endtask

    task automatic test_reset_mid();
        int seen_lo;
        seen_lo = 0;
        fill_samples(3, 16'h1110);
        sample_in = 16'hBEEF;
        sample_valid = 1'b1;
        n_checks++;
        if (fill !== 5'd6 || sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: fill=%0d rdy=%b, required 6 1", fill, sample_ready);
        end
        tick();
        sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (fill !== 5'd0 || data !== 8'h00 || tx_enable !== 1'b0 || underflow_cnt !== 8'h00 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_state: fill=%0d data=%h txen=%b uf=%0d rdy=%b, required 0 00 0 0 0",
                     fill, data, tx_enable, underflow_cnt, sample_ready);
        end
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (data === 8'hEF || fill !== 5'd0) seen_lo++;
        end
        n_checks++;
        if (seen_lo != 0) begin
            n_fail++;
            $display("FAIL rmid_lo_leak: %0d cycles with data=ef or fill!=0, required 0", seen_lo);
        end
    endtask

    task automatic test_odd_fill();
        fill_samples(8, 16'h5060);
        n_checks++;
        if (fill !== 5'd16 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_full: fill=%0d rdy=%b, required 16 0", fill, sample_ready);
        end
        exp_b = exp_q.pop_front();
        n_checks++;
        if (data !== exp_b) begin
            n_fail++;
            $display("FAIL odd_pop1: got %h, required %h", data, exp_b);
        end
        pulse();
        n_checks++;
        if (fill !== 5'd15 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_fill15: fill=%0d rdy=%b, required 15 0", fill, sample_ready);
        end
        exp_b = exp_q.pop_front();
        pulse();
        n_checks++;
        if (fill !== 5'd14 || sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_fill14: fill=%0d rdy=%b, required 14 1", fill, sample_ready);
        end
        fill_samples(1, 16'h7E81);
        n_checks++;
        if (fill !== 5'd16 || sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_refill: fill=%0d rdy=%b, required 16 0", fill, sample_ready);
        end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (data !== exp_b) begin
                n_fail++;
                $display("FAIL odd_drain: got %h, required %h", data, exp_b);
            end
            pulse();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        test_odd_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
